regfile_scoreboard: RTL and testbench

- Parametrised successor to the team's 32x32 register file; generalised in data width, depth, zero-register mode and read latency.
- Adds a clocked write port, write-to-read bypass, asynchronous reset initialisation and a per-register busy scoreboard.
- Sits between decode/issue and the ALU/mux datapath of the pipelined CPU.
- Issue logic uses Busy1/Busy2 to stall on RAW hazards; writeback clears busy.

---
 rtl/regfile_scoreboard.sv | 158 +++++++++++++++
 tb/tb_regfile_scoreboard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with one clocked write port, two read ports with
//   write-first bypass, and a per-register busy scoreboard for RAW hazard stalls.
//
//   Ports:
//     Clk        in   clock, rising edge active
//     Rst        in   asynchronous active-high reset
//     RR1, RR2   in   read addresses
//     Out1, Out2 out  read data (signed), combinational or registered (READ_LAT)
//     Busy1/2    out  addressed register has a pending producer
//     WR, WD, WE in   write address / data / enable
//     IssueAddr  in   destination register of a newly issued instruction
//     IssueEn    in   mark IssueAddr busy
//     IssueErr   out  registered one-cycle pulse on issue to a busy register
module regfile_scoreboard #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned ZERO_REG  = 1,
   parameter int unsigned READ_LAT  = 0,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [ADDR_W-1:0]        RR1,
   input  logic [ADDR_W-1:0]        RR2,
   output logic signed [DATA_W-1:0] Out1,
   output logic signed [DATA_W-1:0] Out2,
   output logic                     Busy1,
   output logic                     Busy2,
   input  logic [ADDR_W-1:0]        WR,
   input  logic signed [DATA_W-1:0] WD,
   input  logic                     WE,
   input  logic [ADDR_W-1:0]        IssueAddr,
   input  logic                     IssueEn,
   output logic                     IssueErr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              issue_err_q;
   logic              issue_err_d;

   logic              wr_ok_s;
   logic              issue_ok_s;
   logic [DATA_W-1:0] value1_s;
   logic [DATA_W-1:0] value2_s;
   logic              busy1_s;
   logic              busy2_s;

   // Register 0 is hard-wired in zero-register mode: no writes, no busy marking.
   assign wr_ok_s    = WE && !((ZERO_REG != 0) && (WR == '0));
   assign issue_ok_s = IssueEn && !((ZERO_REG != 0) && (IssueAddr == '0));

   // Read value per port: zero register first, then write-first bypass, then storage.
   always_comb begin
      value1_s = regs_q[RR1];
      value2_s = regs_q[RR2];
      if ((ZERO_REG != 0) && (RR1 == '0)) begin
         value1_s = '0;
      end else if (wr_ok_s && (WR == RR1)) begin
         value1_s = WD;
      end else begin
         value1_s = regs_q[RR1];
      end
      if ((ZERO_REG != 0) && (RR2 == '0)) begin
         value2_s = '0;
      end else if (wr_ok_s && (WR == RR2)) begin
         value2_s = WD;
      end else begin
         value2_s = regs_q[RR2];
      end
   end

   // A write to the addressed register this cycle forwards data, so it resolves the hazard.
   assign busy1_s = busy_q[RR1] && !(WE && (WR == RR1));
   assign busy2_s = busy_q[RR2] && !(WE && (WR == RR2));

   // Scoreboard next state: a new issue overrides a writeback to the same register.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_ok_s && (IssueAddr == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (WE && (WR == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
   end

   // WAW report: issuing to a register whose producer is not retiring this cycle.
   assign issue_err_d = IssueEn && busy_q[IssueAddr] && !(WE && (WR == IssueAddr));

   // Storage: reset restores the init pattern, otherwise commit the write port.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (INIT_MODE != 0) ? DATA_W'(i) : '0;
         end
      end else if (wr_ok_s) begin
         regs_q[WR] <= WD;
      end else begin
         regs_q[WR] <= regs_q[WR];
      end
   end

   // Scoreboard and WAW pulse registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         busy_q      <= '0;
         issue_err_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         issue_err_q <= issue_err_d;
      end
   end

   assign IssueErr = issue_err_q;

   generate
      if (READ_LAT == 0) begin : g_comb_read
         assign Out1  = value1_s;
         assign Out2  = value2_s;
         assign Busy1 = busy1_s;
         assign Busy2 = busy2_s;
      end else begin : g_reg_read
         logic [DATA_W-1:0] out1_q;
         logic [DATA_W-1:0] out2_q;
         logic              busy1_q;
         logic              busy2_q;

         // Registered read: data and busy appear one cycle after the address.
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               out1_q  <= '0;
               out2_q  <= '0;
               busy1_q <= 1'b0;
               busy2_q <= 1'b0;
            end else begin
               out1_q  <= value1_s;
               out2_q  <= value2_s;
               busy1_q <= busy1_s;
               busy2_q <= busy2_s;
            end
         end

         assign Out1  = out1_q;
         assign Out2  = out2_q;
         assign Busy1 = busy1_q;
         assign Busy2 = busy2_q;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [4:0]  RR1 = 5'd0, RR2 = 5'd0, WR = 5'd0, IssueAddr = 5'd0;
   logic [31:0] WD = 32'd0;
   logic        WE = 1'b0, IssueEn = 1'b0;

   logic signed [31:0] out1_a, out2_a, out1_b, out2_b, out1_c, out2_c;
   logic busy1_a, busy2_a, busy1_b, busy2_b, busy1_c, busy2_c;
   logic ierr_a, ierr_b, ierr_c;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   // a: default parameters, combinational read
   regfile_scoreboard #(.READ_LAT(0), .INIT_MODE(1)) dut_a (
      .Clk(Clk), .Rst(Rst), .RR1(RR1), .RR2(RR2), .Out1(out1_a), .Out2(out2_a),
      .Busy1(busy1_a), .Busy2(busy2_a), .WR(WR), .WD(WD), .WE(WE),
      .IssueAddr(IssueAddr), .IssueEn(IssueEn), .IssueErr(ierr_a));

   // b: registered read
   regfile_scoreboard #(.READ_LAT(1), .INIT_MODE(1)) dut_b (
      .Clk(Clk), .Rst(Rst), .RR1(RR1), .RR2(RR2), .Out1(out1_b), .Out2(out2_b),
      .Busy1(busy1_b), .Busy2(busy2_b), .WR(WR), .WD(WD), .WE(WE),
      .IssueAddr(IssueAddr), .IssueEn(IssueEn), .IssueErr(ierr_b));

   // c: zero-initialised contents
   regfile_scoreboard #(.READ_LAT(0), .INIT_MODE(0)) dut_c (
      .Clk(Clk), .Rst(Rst), .RR1(RR1), .RR2(RR2), .Out1(out1_c), .Out2(out2_c),
      .Busy1(busy1_c), .Busy2(busy2_c), .WR(WR), .WD(WD), .WE(WE),
      .IssueAddr(IssueAddr), .IssueEn(IssueEn), .IssueErr(ierr_c));

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic        ie;
      logic [4:0]  ia;
      logic [31:0] o1;
      logic [31:0] o2;
      logic        b1;
      logic        b2;
      logic        ierr;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(logic we, logic [4:0] wr, logic [31:0] wd,
                               logic [4:0] rr1, logic [4:0] rr2, logic ie, logic [4:0] ia,
                               logic [31:0] o1, logic [31:0] o2, logic b1, logic b2,
                               logic ierr);
      vec_t v;
      v.we = we; v.wr = wr; v.wd = wd; v.rr1 = rr1; v.rr2 = rr2; v.ie = ie; v.ia = ia;
      v.o1 = o1; v.o2 = o2; v.b1 = b1; v.b2 = b2; v.ierr = ierr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      WE = 1'b0; WR = 5'd0; WD = 32'd0; IssueEn = 1'b0; IssueAddr = 5'd0;
   endtask

   initial begin
      //            we    wr     wd            rr1    rr2    ie    ia     o1            o2            b1    b2    ierr
      vecs[0]  = mk(1'b0, 5'd0,  32'd0,        5'd7,  5'd31, 1'b0, 5'd0,  32'd7,        32'd31,       1'b0, 1'b0, 1'b0);
      // -2000 = 32'hFFFFF830, bypassed before the edge
      vecs[1]  = mk(1'b1, 5'd3,  32'hFFFFF830, 5'd3,  5'd4,  1'b0, 5'd0,  32'hFFFFF830, 32'd4,        1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 5'd0,  32'd0,        5'd3,  5'd3,  1'b0, 5'd0,  32'hFFFFF830, 32'hFFFFF830, 1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 5'd0,  32'd1300,     5'd0,  5'd0,  1'b0, 5'd0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 5'd0,  32'd0,        5'd0,  5'd0,  1'b1, 5'd0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0);
      // issue reg 5 (edge k)
      vecs[5]  = mk(1'b0, 5'd0,  32'd0,        5'd0,  5'd5,  1'b1, 5'd5,  32'd0,        32'd5,        1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 5'd0,  32'd0,        5'd5,  5'd5,  1'b0, 5'd0,  32'd5,        32'd5,        1'b1, 1'b1, 1'b0);
      vecs[7]  = mk(1'b0, 5'd0,  32'd0,        5'd0,  5'd5,  1'b0, 5'd0,  32'd0,        32'd5,        1'b0, 1'b1, 1'b0);
      // writeback at edge k+3: forwarded data clears the hazard in-cycle
      vecs[8]  = mk(1'b1, 5'd5,  32'd42,       5'd5,  5'd5,  1'b0, 5'd0,  32'd42,       32'd42,       1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 5'd0,  32'd0,        5'd5,  5'd5,  1'b0, 5'd0,  32'd42,       32'd42,       1'b0, 1'b0, 1'b0);
      // double issue to reg 9
      vecs[10] = mk(1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  32'd9,        32'd0,        1'b0, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  32'd9,        32'd0,        1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b0, 5'd0,  32'd9,        32'd0,        1'b1, 1'b0, 1'b1);
      // issue and writeback to reg 9 on the same edge: set wins, no WAW error
      vecs[13] = mk(1'b1, 5'd9,  32'd99,       5'd9,  5'd0,  1'b1, 5'd9,  32'd99,       32'd0,        1'b0, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 5'd0,  32'd0,        5'd9,  5'd9,  1'b0, 5'd0,  32'd99,       32'd99,       1'b1, 1'b1, 1'b0);
      vecs[15] = mk(1'b1, 5'd31, 32'h80000000, 5'd31, 5'd30, 1'b0, 5'd0,  32'h80000000, 32'd30,       1'b0, 1'b0, 1'b0);
      vecs[16] = mk(1'b0, 5'd0,  32'd0,        5'd31, 5'd1,  1'b0, 5'd0,  32'h80000000, 32'd1,        1'b0, 1'b0, 1'b0);

      // Reset pulse entirely between clock edges (posedges at 5, 15, ...)
      #6 Rst = 1'b1;
      #3 Rst = 1'b0;
      #2 RR1 = 5'd7; RR2 = 5'd31;
      #1;
      chk("rst_a_out1", out1_a, 32'd7);
      chk("rst_a_out2", out2_a, 32'd31);
      chk("rst_a_busy", {30'd0, busy1_a, busy2_a}, 32'd0);
      chk("rst_a_ierr", {31'd0, ierr_a}, 32'd0);
      chk("rst_c_out1", out1_c, 32'd0);
      chk("rst_c_out2", out2_c, 32'd0);
      chk("rst_b_out1", out1_b, 32'd0);
      chk("rst_b_busy", {30'd0, busy1_b, busy2_b}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         @(negedge Clk);
         WE = vecs[i].we; WR = vecs[i].wr; WD = vecs[i].wd;
         RR1 = vecs[i].rr1; RR2 = vecs[i].rr2;
         IssueEn = vecs[i].ie; IssueAddr = vecs[i].ia;
         #2;
         chk($sformatf("v%0d_out1", i), out1_a, vecs[i].o1);
         chk($sformatf("v%0d_out2", i), out2_a, vecs[i].o2);
         chk($sformatf("v%0d_busy1", i), {31'd0, busy1_a}, {31'd0, vecs[i].b1});
         chk($sformatf("v%0d_busy2", i), {31'd0, busy2_a}, {31'd0, vecs[i].b2});
         chk($sformatf("v%0d_ierr", i), {31'd0, ierr_a}, {31'd0, vecs[i].ierr});
      end

      // Registered read: busy[9] still set, reg 9 = 99
      @(negedge Clk);
      idle(); RR1 = 5'd9; RR2 = 5'd0;
      @(posedge Clk); #1;
      chk("lat1_busy1", {31'd0, busy1_b}, 32'd1);
      chk("lat1_out1_r9", out1_b, 32'd99);
      chk("lat1_out2_r0", out2_b, 32'd0);

      // Registered read of a write committed on the same edge
      @(negedge Clk);
      WE = 1'b1; WR = 5'd3; WD = 32'd77; RR1 = 5'd3;
      @(posedge Clk); #1;
      chk("lat1_out1_wr", out1_b, 32'd77);
      chk("lat1_busy1_wr", {31'd0, busy1_b}, 32'd0);

      // Mid-cycle reset clears registered outputs immediately
      #2 Rst = 1'b1;
      #1;
      chk("lat1_rst_out1", out1_b, 32'd0);
      chk("lat1_rst_busy1", {31'd0, busy1_b}, 32'd0);
      chk("rst_ierr", {31'd0, ierr_a}, 32'd0);

      // Write and issue on an edge coincident with reset are discarded
      WE = 1'b1; WR = 5'd4; WD = 32'd555; IssueEn = 1'b1; IssueAddr = 5'd6;
      @(posedge Clk); #2;
      Rst = 1'b0;
      idle(); RR1 = 5'd4; RR2 = 5'd6;
      #1;
      chk("post_rst_r4", out1_a, 32'd4);
      chk("post_rst_r6", out2_a, 32'd6);
      chk("post_rst_busy6", {31'd0, busy2_a}, 32'd0);
      chk("post_rst_c_r4", out1_c, 32'd0);
      RR1 = 5'd3; RR2 = 5'd9;
      #1;
      chk("post_rst_r3", out1_a, 32'd3);
      chk("post_rst_busy9", {31'd0, busy2_a}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
